// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, starve
// counter width and the memory-port source select.
package dmem_arbiter_pkg;

  localparam logic [0:0] ARB_RUN  = 1'b0;
  localparam logic [0:0] ARB_HALT = 1'b1;

  localparam int ARB_STARVE_W = 8;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_DBG = 1'b1
  } mem_src_e;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with clear priority; o_at_limit flags the cap.
module sat_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam logic [WIDTH-1:0] LIM_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIM_V)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_at_limit = (r_count == LIM_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the CPU load/store path and a
// debug/loader master; CPU has priority unless debug starves or holds a halt.
//
//  state | meaning
//  RUN   | CPU owns the port; debug served in idle cycles or after starving
//  HALT  | CPU held stalled; debug owns the port every cycle
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DBITS        = 32,
  parameter int ADDR_BITS    = 30,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic [DBITS-1:0]     cpu_wdata,
  output logic [DBITS-1:0]     cpu_rdata,
  output logic                 cpu_stall,
  input  logic                 dbg_halt,
  output logic                 dbg_halted,
  input  logic                 dbg_valid,
  input  logic                 dbg_we,
  input  logic [ADDR_BITS-1:0] dbg_addr,
  input  logic [DBITS-1:0]     dbg_wdata,
  output logic                 dbg_ready,
  output logic                 dbg_rsp_valid,
  output logic [DBITS-1:0]     dbg_rdata,
  output logic                 mem_en_write,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DBITS-1:0]     mem_data_in,
  input  logic [DBITS-1:0]     mem_data_out
);

  logic [0:0]     r_state;
  logic [0:0]     w_state_nxt;
  logic           w_halt;
  logic           w_ready;
  logic           w_grant;
  logic           w_stall;
  logic           w_at_limit;
  logic           w_starve_inc;
  logic           w_starve_clr;
  logic           w_rd_accept;
  mem_src_e       w_src;
  logic           r_rsp_valid;
  logic [DBITS-1:0] r_rdata;

  always_comb begin
    w_state_nxt = ARB_RUN;
    if (dbg_halt) begin
      w_state_nxt = ARB_HALT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ARB_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_halt = (r_state == ARB_HALT);

  // Outputs that could cause an access are forced quiet while reset is held.
  assign w_ready = reset & (w_halt | ~cpu_req | w_at_limit);
  assign w_grant = dbg_valid & w_ready;
  assign w_stall = reset & (w_halt | (w_grant & cpu_req));
  assign w_src   = w_grant ? SRC_DBG : SRC_CPU;

  assign w_starve_inc = ~w_halt & dbg_valid & ~w_ready;
  assign w_starve_clr = w_halt | ~dbg_valid | w_grant;

  sat_counter #(
    .WIDTH (ARB_STARVE_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (w_starve_inc),
    .i_clr      (w_starve_clr),
    .o_at_limit (w_at_limit)
  );

  always_comb begin
    mem_addr     = cpu_addr;
    mem_data_in  = cpu_wdata;
    mem_en_write = 1'b0;
    case (w_src)
      SRC_DBG: begin
        mem_addr     = dbg_addr;
        mem_data_in  = dbg_wdata;
        mem_en_write = reset & dbg_we;
      end
      default: begin
        mem_addr     = cpu_addr;
        mem_data_in  = cpu_wdata;
        mem_en_write = reset & cpu_we & ~w_stall;
      end
    endcase
  end

  assign w_rd_accept = w_grant & ~dbg_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_rdata <= mem_data_out;
      end
    end
  end

  assign cpu_rdata     = mem_data_out;
  assign cpu_stall     = w_stall;
  assign dbg_ready     = w_ready;
  assign dbg_halted    = w_halt;
  assign dbg_rsp_valid = r_rsp_valid;
  assign dbg_rdata     = r_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a word-array memory, a rule-level
// reference model compared every cycle, and directed scenarios with literals.
module tb_dmem_arbiter;

  localparam int DB  = 32;
  localparam int AB  = 30;
  localparam int LIM = 8;

  logic          clk;
  logic          reset;
  logic          cpu_req;
  logic          cpu_we;
  logic [AB-1:0] cpu_addr;
  logic [DB-1:0] cpu_wdata;
  logic [DB-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          dbg_halt;
  logic          dbg_halted;
  logic          dbg_valid;
  logic          dbg_we;
  logic [AB-1:0] dbg_addr;
  logic [DB-1:0] dbg_wdata;
  logic          dbg_ready;
  logic          dbg_rsp_valid;
  logic [DB-1:0] dbg_rdata;
  logic          mem_en_write;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_data_in;
  logic [DB-1:0] mem_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.DBITS(DB), .ADDR_BITS(AB), .STARVE_LIMIT(LIM)) dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_req       (cpu_req),
    .cpu_we        (cpu_we),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .cpu_rdata     (cpu_rdata),
    .cpu_stall     (cpu_stall),
    .dbg_halt      (dbg_halt),
    .dbg_halted    (dbg_halted),
    .dbg_valid     (dbg_valid),
    .dbg_we        (dbg_we),
    .dbg_addr      (dbg_addr),
    .dbg_wdata     (dbg_wdata),
    .dbg_ready     (dbg_ready),
    .dbg_rsp_valid (dbg_rsp_valid),
    .dbg_rdata     (dbg_rdata),
    .mem_en_write  (mem_en_write),
    .mem_addr      (mem_addr),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory driven by the DUT's port
  logic [DB-1:0] mem_b [256];
  always @(posedge clk) if (mem_en_write) mem_b[mem_addr[7:0]] <= mem_data_in;
  assign mem_data_out = mem_b[mem_addr[7:0]];

  // Reference model
  logic [DB-1:0] m_mem [256];
  bit            m_halted;
  int            m_starve;
  bit            m_rsp;
  logic [DB-1:0] m_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_halted = 0;
      m_starve = 0;
      m_rsp    = 0;
      m_rdata  = '0;
    end else begin
      bit ready, grant, stall;
      ready = m_halted || !cpu_req || (m_starve == LIM);
      grant = dbg_valid && ready;
      stall = m_halted || (grant && cpu_req);
      m_rsp = grant && !dbg_we;
      if (m_rsp) m_rdata = m_mem[dbg_addr[7:0]];
      if (grant && dbg_we) m_mem[dbg_addr[7:0]] = dbg_wdata;
      else if (!grant && cpu_we && !stall) m_mem[cpu_addr[7:0]] = cpu_wdata;
      if (m_halted || !dbg_valid || grant) m_starve = 0;
      else if (m_starve < LIM) m_starve = m_starve + 1;
      m_halted = dbg_halt;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_ready", {31'd0, dbg_ready}, 0);
      chk("rst_stall", {31'd0, cpu_stall}, 0);
      chk("rst_wen", {31'd0, mem_en_write}, 0);
      chk("rst_rsp", {31'd0, dbg_rsp_valid}, 0);
      chk("rst_rdata", dbg_rdata, 0);
      chk("rst_halted", {31'd0, dbg_halted}, 0);
    end else begin
      bit ready, grant, stall, wen;
      logic [AB-1:0] a;
      logic [DB-1:0] wd;
      ready = m_halted || !cpu_req || (m_starve == LIM);
      grant = dbg_valid && ready;
      stall = m_halted || (grant && cpu_req);
      wen   = grant ? dbg_we : (cpu_we && !stall);
      a     = grant ? dbg_addr : cpu_addr;
      wd    = grant ? dbg_wdata : cpu_wdata;
      chk("m_ready", {31'd0, dbg_ready}, {31'd0, ready});
      chk("m_stall", {31'd0, cpu_stall}, {31'd0, stall});
      chk("m_wen", {31'd0, mem_en_write}, {31'd0, wen});
      chk("m_addr", {2'b00, mem_addr}, {2'b00, a});
      if (wen) chk("m_wdata", mem_data_in, wd);
      chk("m_cpu_rdata", cpu_rdata, m_mem[a[7:0]]);
      chk("m_rsp", {31'd0, dbg_rsp_valid}, {31'd0, m_rsp});
      chk("m_rdata", dbg_rdata, m_rdata);
      chk("m_halted", {31'd0, dbg_halted}, {31'd0, m_halted});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles until dbg_ready is seen, then steps past that accept edge.
  task automatic wait_ready(input int budget, output int n);
    n = -1;
    for (int k = 0; k < budget; k++) begin
      #1;
      if (dbg_ready) begin
        n = k;
        chk("grant_stall", {31'd0, cpu_stall}, {31'd0, cpu_req});
        cyc();
        return;
      end
      cyc();
    end
  endtask

  int n;
  int acc;

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_halt = 0; dbg_valid = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem_b[i] <= '0;
      m_mem[i] = '0;
    end
    mem_b[8'h10] <= 32'hDEADBEEF;
    m_mem[8'h10] = 32'hDEADBEEF;
    @(posedge clk); #2;
    chk("reset_ready", {31'd0, dbg_ready}, 0);
    chk("reset_halted", {31'd0, dbg_halted}, 0);
    chk("reset_rsp", {31'd0, dbg_rsp_valid}, 0);
    cyc();
    reset = 1'b1;

    // 1: CPU idle, debug read
    dbg_valid = 1; dbg_we = 0; dbg_addr = 30'h10;
    #1;
    chk("t1_ready", {31'd0, dbg_ready}, 1);
    chk("t1_stall", {31'd0, cpu_stall}, 0);
    cyc();
    dbg_valid = 0;
    #1;
    chk("t1_rsp", {31'd0, dbg_rsp_valid}, 1);
    chk("t1_rdata", dbg_rdata, 32'hDEADBEEF);
    cyc();
    chk("t1_rsp_pulse", {31'd0, dbg_rsp_valid}, 0);

    // 2: starving debug write under continuous CPU traffic
    cpu_req = 1; cpu_we = 0; cpu_addr = 30'h30;
    dbg_valid = 1; dbg_we = 1; dbg_addr = 30'h50; dbg_wdata = 32'hA5A50001;
    wait_ready(20, n);
    dbg_valid = 0;
    chk("t2_ready_cycle", n, LIM);
    chk("t2_mem", mem_b[8'h50], 32'hA5A50001);
    cyc();

    // 3: same-address collision, CPU wins until forced grant
    cpu_we = 1; cpu_addr = 30'h20; cpu_wdata = 32'h5;
    dbg_valid = 1; dbg_we = 1; dbg_addr = 30'h20; dbg_wdata = 32'h7;
    #1;
    chk("t3_ready0", {31'd0, dbg_ready}, 0);
    cyc();
    chk("t3_mem_cpu", mem_b[8'h20], 32'h5);
    wait_ready(20, n);
    chk("t3_ready_cycle", n, LIM - 1);
    chk("t3_mem_dbg", mem_b[8'h20], 32'h7);
    cpu_we = 0; dbg_valid = 0;
    cyc();

    // 4: halt and stream 16 writes
    dbg_halt = 1; cpu_we = 1; cpu_addr = 30'h60; cpu_wdata = 32'h99;
    cyc();
    chk("t4_halted", {31'd0, dbg_halted}, 1);
    chk("t4_stall", {31'd0, cpu_stall}, 1);
    chk("t4_mem_cpu", mem_b[8'h60], 32'h99);
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      dbg_valid = 1; dbg_we = 1; dbg_addr = 30'h80 + 30'(i); dbg_wdata = 32'h1000 + 32'(i);
      #1;
      if (dbg_ready) acc++;
      cyc();
    end
    chk("t4_accepts", acc, 16);
    dbg_we = 0; dbg_addr = 30'h8F;
    cyc();
    dbg_valid = 0;
    #1;
    chk("t4_rb_rsp", {31'd0, dbg_rsp_valid}, 1);
    chk("t4_rb_data", dbg_rdata, 32'h100F);
    chk("t4_mem_cpu_kept", mem_b[8'h60], 32'h99);
    dbg_halt = 0; cpu_we = 0;
    cyc();
    chk("t4_run", {31'd0, dbg_halted}, 0);
    chk("t4_unstall", {31'd0, cpu_stall}, 0);

    // 5: reset before the read's accept edge
    cpu_req = 0; cpu_we = 0;
    dbg_valid = 1; dbg_we = 0; dbg_addr = 30'h10;
    #1;
    chk("t5_ready", {31'd0, dbg_ready}, 1);
    reset = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 30'h70; cpu_wdata = 32'h77;
    dbg_we = 1; dbg_addr = 30'h71; dbg_wdata = 32'h71;
    #1;
    chk("t5_wen", {31'd0, mem_en_write}, 0);
    chk("t5_stall", {31'd0, cpu_stall}, 0);
    cyc();
    chk("t5_rsp", {31'd0, dbg_rsp_valid}, 0);
    chk("t5_rdata", dbg_rdata, 0);
    chk("t5_halted", {31'd0, dbg_halted}, 0);
    cyc();
    chk("t5_mem70", mem_b[8'h70], 0);
    chk("t5_mem71", mem_b[8'h71], 0);
    cpu_req = 0; cpu_we = 0; dbg_valid = 0; dbg_we = 0;
    reset = 1;
    cyc();

    // 6: debug request withdrawn before acceptance
    cpu_req = 1; cpu_we = 0; cpu_addr = 30'h30;
    dbg_valid = 1; dbg_we = 1; dbg_addr = 30'h90; dbg_wdata = 32'h6;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_ready0", {31'd0, dbg_ready}, 0);
      chk("t6_wen0", {31'd0, mem_en_write}, 0);
      cyc();
    end
    dbg_valid = 0;
    cyc();
    chk("t6_mem_untouched", mem_b[8'h90], 0);
    dbg_valid = 1;
    wait_ready(20, n);
    dbg_valid = 0;
    chk("t6_ready_cycle", n, LIM);
    chk("t6_mem", mem_b[8'h90], 32'h6);

    repeat (2) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
